// File: rtl/mdrp_pll_cfg_seq.sv
// Purpose: read-modify-write PLL programming over MDRP from a host-loaded multi-profile table, then lock qualification with retry/fallback/relock.
// Latency: 4-cycle reset pulse, then per entry 1 fetch + (addr delta) seek + RD_LAT read + 1 write; lock needs LOCK_STABLE_CYC synced cycles.
// Backpressure: none; I_START and table writes are ignored while O_BUSY is high.
module mdrp_pll_cfg_seq #(
  parameter int NUM_PROF        = 4,
  parameter int ENT_PER_PROF    = 8,
  parameter int RD_LAT          = 2,
  parameter int LOCK_TO_CYC     = 40000,
  parameter int LOCK_STABLE_CYC = 10000,
  parameter int MAX_RETRY       = 2,
  parameter int AUTO_FALLBACK   = 1,
  parameter int RELOCK_EN       = 1
) (
  input  logic                                      I_MD_CLK,
  input  logic                                      I_RST_N,
  input  logic                                      I_TBL_WE,
  input  logic [$clog2(NUM_PROF*ENT_PER_PROF)-1:0]  I_TBL_ADDR,
  input  logic [24:0]                               I_TBL_WDATA,
  input  logic                                      I_START,
  input  logic [$clog2(NUM_PROF)-1:0]               I_PROFILE,
  output logic                                      O_BUSY,
  output logic                                      O_DONE,
  output logic [1:0]                                O_ERR,
  output logic [$clog2(NUM_PROF)-1:0]               O_ACT_PROF,
  output logic                                      O_LOCK,
  output logic                                      O_PLL_RST,
  output logic                                      O_MD_INC,
  output logic [1:0]                                O_MD_OPC,
  output logic [7:0]                                O_MD_WR_DATA,
  input  logic [7:0]                                I_MD_RD_DATA,
  input  logic                                      I_LOCK
);

  localparam int DEPTH = NUM_PROF * ENT_PER_PROF;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(NUM_PROF);
  localparam int EW    = $clog2(ENT_PER_PROF + 1);
  localparam int CW    = $clog2(LOCK_TO_CYC + RD_LAT + 5);
  localparam int SW    = $clog2(LOCK_STABLE_CYC + 1);
  localparam int RW    = $clog2(MAX_RETRY + 2);
  localparam int TW    = $clog2(NUM_PROF + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_PRESET    = 4'd1;
  localparam logic [3:0] S_FETCH     = 4'd2;
  localparam logic [3:0] S_SEEK      = 4'd3;
  localparam logic [3:0] S_READ      = 4'd4;
  localparam logic [3:0] S_WRITE     = 4'd5;
  localparam logic [3:0] S_LOCK_WAIT = 4'd6;
  localparam logic [3:0] S_LOCKED    = 4'd7;
  localparam logic [3:0] S_FAIL      = 4'd8;

  logic [24:0]   tbl [DEPTH];
  logic [24:0]   tbl_q;
  logic [3:0]    state;
  logic [PW-1:0] prof_q, act_prof, prof_nxt;
  logic [RW-1:0] retry;
  logic [TW-1:0] tried;
  logic [EW-1:0] ent, ent_nxt;
  logic [7:0]    shadow, rd_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stab;
  logic [1:0]    err;
  logic          done_q, lock_q, lock_m, lock_s, busy, tbl_ld;
  logic [AW-1:0] rd_idx;

  wire       e_vld  = tbl_q[24];
  wire [7:0] e_addr = tbl_q[23:16];
  wire [7:0] e_mask = tbl_q[15:8];
  wire [7:0] e_data = tbl_q[7:0];

  assign busy     = (state == S_PRESET) || (state == S_FETCH) || (state == S_SEEK) ||
                    (state == S_READ) || (state == S_WRITE) || (state == S_LOCK_WAIT);
  assign ent_nxt  = ent + EW'(1);
  assign prof_nxt = (prof_q == PW'(NUM_PROF - 1)) ? '0 : prof_q + PW'(1);
  // Entry 0 is preloaded during the reset pulse; the next entry is loaded while writing the current one.
  assign rd_idx   = AW'(int'(prof_q) * ENT_PER_PROF) + ((state == S_WRITE) ? AW'(ent_nxt) : '0);
  assign tbl_ld   = (state == S_PRESET) || ((state == S_WRITE) && (ent_nxt < EW'(ENT_PER_PROF)));

  // Table storage: host writes land only while idle; registered read port feeds FETCH.
  always_ff @(posedge I_MD_CLK) begin
    if (I_TBL_WE && !busy) tbl[I_TBL_ADDR] <= I_TBL_WDATA;
    if (tbl_ld) tbl_q <= tbl[rd_idx];
  end

  // Two-flop synchroniser for the asynchronous raw lock.
  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= I_LOCK;
      lock_s <= lock_m;
    end
  end

  // Sequencer: programming walk, lock qualification, retry/fallback/relock.
  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state    <= S_IDLE;
      prof_q   <= '0;
      act_prof <= '0;
      retry    <= '0;
      tried    <= '0;
      ent      <= '0;
      shadow   <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      stab     <= '0;
      err      <= 2'd0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lock_q <= 1'b0;
      case (state)
        S_IDLE, S_LOCKED, S_FAIL: begin
          if (I_START) begin
            prof_q   <= I_PROFILE;
            act_prof <= I_PROFILE;
            retry    <= '0;
            tried    <= '0;
            err      <= 2'd0;
            cnt      <= '0;
            state    <= S_PRESET;
          end else if (state == S_LOCKED) begin
            if (!lock_s && (RELOCK_EN != 0)) begin
              act_prof <= prof_q;
              retry    <= '0;
              tried    <= '0;
              cnt      <= '0;
              state    <= S_PRESET;
            end else begin
              lock_q <= lock_s;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_PRESET: begin
          shadow <= '0;
          ent    <= '0;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(3)) state <= S_FETCH;
        end
        S_FETCH: begin
          cnt <= '0;
          if (ent == EW'(ENT_PER_PROF) || !e_vld) begin
            stab  <= '0;
            state <= S_LOCK_WAIT;
          end else if (e_addr < shadow) begin
            err    <= 2'd2;
            done_q <= 1'b1;
            state  <= S_FAIL;
          end else if (e_addr == shadow) begin
            state <= S_READ;
          end else begin
            state <= S_SEEK;
          end
        end
        S_SEEK: begin
          shadow <= shadow + 8'd1;
          if (shadow + 8'd1 == e_addr) state <= S_READ;
        end
        S_READ: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(RD_LAT - 1)) begin
            rd_q  <= I_MD_RD_DATA;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          ent   <= ent_nxt;
          state <= S_FETCH;
        end
        S_LOCK_WAIT: begin
          stab <= lock_s ? stab + SW'(1) : '0;
          cnt  <= cnt + CW'(1);
          if (stab == SW'(LOCK_STABLE_CYC)) begin
            lock_q <= 1'b1;
            done_q <= 1'b1;
            err    <= 2'd0;
            state  <= S_LOCKED;
          end else if (cnt == CW'(LOCK_TO_CYC)) begin
            cnt <= '0;
            if (retry < RW'(MAX_RETRY)) begin
              retry    <= retry + RW'(1);
              act_prof <= prof_q;
              state    <= S_PRESET;
            end else if ((AUTO_FALLBACK != 0) && (tried < TW'(NUM_PROF - 1))) begin
              tried    <= tried + TW'(1);
              retry    <= '0;
              prof_q   <= prof_nxt;
              act_prof <= prof_nxt;
              state    <= S_PRESET;
            end else begin
              err    <= 2'd1;
              done_q <= 1'b1;
              state  <= S_FAIL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PLL reset is released for programming and lock; asserted while idle, pulsing or failed.
  assign O_PLL_RST    = (state == S_IDLE) || (state == S_PRESET) || (state == S_FAIL);
  assign O_MD_INC     = (state == S_SEEK);
  assign O_MD_OPC     = (state == S_READ) ? 2'b10 : (state == S_WRITE) ? 2'b01 : 2'b00;
  assign O_MD_WR_DATA = (state == S_WRITE) ? ((rd_q & ~e_mask) | (e_data & e_mask)) : 8'h00;
  assign O_BUSY       = busy;
  assign O_DONE       = done_q;
  assign O_ERR        = err;
  assign O_ACT_PROF   = act_prof;
  assign O_LOCK       = lock_q;

endmodule

// File: tb/tb_mdrp_pll_cfg_seq.sv
// Directed bench for mdrp_pll_cfg_seq with shortened lock timers.
// Expected MDRP write values, seek lengths and outcomes are hand-computed from the table contents.
// A passive monitor logs MDRP traffic; the stimulus block compares against constants.
module tb_mdrp_pll_cfg_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tbl_we;
  logic [4:0] tbl_addr;
  logic [24:0] tbl_wdata;
  logic       start;
  logic [1:0] profile;
  logic       o_busy, o_done, o_lock, o_pll_rst, o_md_inc;
  logic [1:0] o_err, o_act_prof, o_md_opc;
  logic [7:0] o_md_wr_data;
  logic [7:0] rd_data;
  logic       i_lock;

  int n_vec = 0;
  int n_bad = 0;

  // monitor state
  int cyc = 0, inc_cnt = 0, rd_cyc = 0, wr_n = 0, viol = 0, ep = 0, done_cyc = 0;
  int wr_val [64];
  int wr_inc [64];
  int wr_cyc [64];
  logic pll_prev = 1'b1;

  // lock stimulus: 0 never, 1 high (minus glitch), 2 high only for profile 3 out of reset
  int   lock_mode = 0;
  logic glitch = 1'b0;

  always #5 clk = ~clk;

  mdrp_pll_cfg_seq #(
    .NUM_PROF(4), .ENT_PER_PROF(8), .RD_LAT(2), .LOCK_TO_CYC(40),
    .LOCK_STABLE_CYC(10), .MAX_RETRY(2), .AUTO_FALLBACK(1), .RELOCK_EN(1)
  ) dut (
    .I_MD_CLK(clk), .I_RST_N(rst_n), .I_TBL_WE(tbl_we), .I_TBL_ADDR(tbl_addr),
    .I_TBL_WDATA(tbl_wdata), .I_START(start), .I_PROFILE(profile),
    .O_BUSY(o_busy), .O_DONE(o_done), .O_ERR(o_err), .O_ACT_PROF(o_act_prof),
    .O_LOCK(o_lock), .O_PLL_RST(o_pll_rst), .O_MD_INC(o_md_inc), .O_MD_OPC(o_md_opc),
    .O_MD_WR_DATA(o_md_wr_data), .I_MD_RD_DATA(rd_data), .I_LOCK(i_lock)
  );

  // passive MDRP / reset-episode monitor
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (o_md_inc) inc_cnt++;
      if (o_md_opc == 2'b10) rd_cyc++;
      if (o_md_opc == 2'b01 && wr_n < 64) begin
        wr_val[wr_n] = int'(o_md_wr_data);
        wr_inc[wr_n] = inc_cnt;
        wr_cyc[wr_n] = cyc;
        wr_n++;
      end
      if (o_md_inc && o_md_opc != 2'b00) viol++;
      if (o_md_opc == 2'b11) viol++;
      if (pll_prev && !o_pll_rst) ep++;
      if (o_done) done_cyc = cyc;
    end
    pll_prev = o_pll_rst;
  end

  // raw lock driver, updated just after the monitor/stimulus
  always @(negedge clk) begin
    #2;
    case (lock_mode)
      1:       i_lock = ~glitch;
      2:       i_lock = (o_act_prof == 2'd3) && !o_pll_rst;
      default: i_lock = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tbl_wr(input int idx, input logic v, input logic [7:0] a, input logic [7:0] m,
                        input logic [7:0] d);
    tbl_we    = 1'b1;
    tbl_addr  = 5'(idx);
    tbl_wdata = {v, a, m, d};
    tick();
    tbl_we    = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] p);
    start   = 1'b1;
    profile = p;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int wb, ib, rb, eb, found;
    rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    start = 1'b0; profile = '0; rd_data = 8'hFF; i_lock = 1'b0;
    repeat (3) tick();

    // reset values
    check("rst_pll_rst", o_pll_rst, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_lock", o_lock, 0);
    check("rst_inc", o_md_inc, 0);
    check("rst_opc", o_md_opc, 0);
    check("rst_wdat", o_md_wr_data, 0);
    check("rst_err", o_err, 0);
    check("rst_prof", o_act_prof, 0);
    rst_n = 1'b1;
    tick();

    // table: p0 empty, p1 two entries, p2/p3 one entry each
    tbl_wr(0,  1'b0, 8'h00, 8'h00, 8'h00);
    tbl_wr(8,  1'b1, 8'h0B, 8'h3F, 8'h01);
    tbl_wr(9,  1'b1, 8'h11, 8'h07, 8'h03);
    tbl_wr(10, 1'b0, 8'h00, 8'h00, 8'h00);
    tbl_wr(16, 1'b1, 8'h05, 8'hF0, 8'hA0);
    tbl_wr(17, 1'b0, 8'h00, 8'h00, 8'h00);
    tbl_wr(24, 1'b1, 8'h07, 8'h0F, 8'h05);
    tbl_wr(25, 1'b0, 8'h00, 8'h00, 8'h00);

    // A: profile 1 programs and locks
    lock_mode = 1;
    wb = wr_n; ib = inc_cnt; rb = rd_cyc;
    do_start(2'd1);
    check("A_busy", o_busy, 1);
    wait_done(2000, ok);
    check("A_done_seen", ok, 1);
    check("A_err", o_err, 0);
    check("A_lock", o_lock, 1);
    check("A_busy_end", o_busy, 0);
    check("A_prof", o_act_prof, 1);
    check("A_nwr", wr_n - wb, 2);
    check("A_wr0", wr_val[wb], 8'hC1);
    check("A_wr1", wr_val[wb+1], 8'hFB);
    check("A_inc0", wr_inc[wb] - ib, 11);
    check("A_inc1", wr_inc[wb+1] - wr_inc[wb], 6);
    check("A_rdcyc", rd_cyc - rb, 4);
    check("A_lock_lat", done_cyc - wr_cyc[wb+1], 13);
    tick();
    check("A_done_pulse", o_done, 0);
    check("A_lock_hold", o_lock, 1);

    // B: one-cycle lock drop while locked -> relock with full reprogram
    wb = wr_n;
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_pll_rst) begin
        found = 1;
        break;
      end
      tick();
    end
    check("B_pll_rst", found, 1);
    check("B_lock_drop", o_lock, 0);
    check("B_busy", o_busy, 1);
    wait_done(2000, ok);
    check("B_done_seen", ok, 1);
    check("B_nwr", wr_n - wb, 2);
    check("B_wr0", wr_val[wb], 8'hC1);
    check("B_wr1", wr_val[wb+1], 8'hFB);
    check("B_lock", o_lock, 1);

    // C: lock never asserts; every profile tried 3 times (order 1,2,3,0)
    lock_mode = 0;
    wb = wr_n; eb = ep;
    do_start(2'd1);
    wait_done(4000, ok);
    check("C_done_seen", ok, 1);
    check("C_err", o_err, 1);
    check("C_episodes", ep - eb, 12);
    check("C_nwr", wr_n - wb, 12);
    check("C_pll_rst", o_pll_rst, 1);
    check("C_lock", o_lock, 0);
    check("C_prof", o_act_prof, 0);
    tick();
    check("C_pll_rst_hold", o_pll_rst, 1);
    check("C_err_hold", o_err, 1);

    // D: profile 2 fails, fallback to profile 3 locks
    lock_mode = 2;
    eb = ep;
    do_start(2'd2);
    wait_done(2000, ok);
    check("D_done_seen", ok, 1);
    check("D_err", o_err, 0);
    check("D_prof", o_act_prof, 3);
    check("D_episodes", ep - eb, 4);
    check("D_lock", o_lock, 1);

    // E: descending table addresses in profile 0
    tbl_wr(0, 1'b1, 8'h12, 8'hFF, 8'h5A);
    tbl_wr(1, 1'b1, 8'h0C, 8'hFF, 8'h00);
    lock_mode = 0;
    wb = wr_n; ib = inc_cnt;
    do_start(2'd0);
    wait_done(2000, ok);
    check("E_done_seen", ok, 1);
    check("E_err", o_err, 2);
    check("E_nwr", wr_n - wb, 1);
    check("E_wr0", wr_val[wb], 8'h5A);
    check("E_inc0", wr_inc[wb] - ib, 18);
    check("E_pll_rst", o_pll_rst, 1);
    wb = wr_n; ib = inc_cnt; rb = rd_cyc;
    repeat (20) tick();
    check("E_quiet", (wr_n - wb) + (inc_cnt - ib) + (rd_cyc - rb), 0);

    // F: reset mid-seek, then clean restart
    lock_mode = 1;
    do_start(2'd1);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (o_md_inc) begin
        found = 1;
        break;
      end
      tick();
    end
    check("F_seek_seen", found, 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("F_pll_rst", o_pll_rst, 1);
    check("F_inc", o_md_inc, 0);
    check("F_busy", o_busy, 0);
    check("F_opc", o_md_opc, 0);
    check("F_prof", o_act_prof, 0);
    check("F_err", o_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    wb = wr_n; ib = inc_cnt;
    do_start(2'd1);
    wait_done(2000, ok);
    check("F_done_seen", ok, 1);
    check("F_inc0", wr_inc[wb] - ib, 11);
    check("F_wr0", wr_val[wb], 8'hC1);
    check("F_wr1", wr_val[wb+1], 8'hFB);
    check("F_err_end", o_err, 0);

    // G: table write and start in the same cycle -> new entry used
    wb = wr_n; ib = inc_cnt;
    tbl_we = 1'b1; tbl_addr = 5'd8; tbl_wdata = {1'b1, 8'h02, 8'hFF, 8'h33};
    start = 1'b1; profile = 2'd1;
    tick();
    tbl_we = 1'b0; start = 1'b0;
    wait_done(2000, ok);
    check("G_done_seen", ok, 1);
    check("G_wr0", wr_val[wb], 8'h33);
    check("G_inc0", wr_inc[wb] - ib, 2);
    check("G_inc1", wr_inc[wb+1] - wr_inc[wb], 15);
    check("G_wr1", wr_val[wb+1], 8'hFB);

    check("inc_opc_exclusive", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
